// File: rtl/snn_image_loader.sv
// snn_image_loader: unpacks a binary image arriving as UART bytes into the
// 1-bit-wide input-image RAM (one pixel per cycle, LSB of each byte first),
// pulses strt to snn_core once the last pixel is written, then holds off
// further bytes until snn_core reports done.
//
// Optional feature: define SNN_LOADER_TIMEOUT_EN to abort a partial frame
// after TIMEOUT_CYCLES idle cycles between bytes (reported on frame_err).
module snn_image_loader #(
    parameter int NUM_PIXELS     = 784,
    parameter int ADDR_W         = 10,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_rdy,
    input  logic [7:0]        rx_data,
    output logic              clr_rx_rdy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_data,
    output logic              strt,
    input  logic              done,
    output logic              busy,
    output logic              frame_err
);

    typedef enum logic [1:0] {
        WAIT_BYTE,
        WRITE,
        START,
        BUSY
    } state_t;

    // Index of the final pixel; writing it completes the frame.
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NUM_PIXELS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [7:0]          byte_q, byte_d;
    logic [2:0]          bit_q, bit_d;
    logic                clr_q, clr_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                data_q, data_d;
    logic                strt_q, strt_d;
    logic                busy_q, busy_d;

`ifdef SNN_LOADER_TIMEOUT_EN
    localparam int             GAP_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                frame_err_q, frame_err_d;
`endif

    // Next-state and registered-output computation for the loader FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        pix_cnt_d = pix_cnt_q;
        byte_d    = byte_q;
        bit_d     = bit_q;
        clr_d     = 1'b0;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        strt_d    = 1'b0;
        busy_d    = busy_q;
`ifdef SNN_LOADER_TIMEOUT_EN
        gap_d       = gap_q;
        frame_err_d = 1'b0;
`endif

        unique case (state_q)
            WAIT_BYTE: begin
                if (rx_rdy) begin
                    // Accept the byte and issue its bit 0 write in the same edge,
                    // so the acknowledge and the first write appear together.
                    byte_d    = rx_data;
                    clr_d     = 1'b1;
                    busy_d    = 1'b1;
                    we_d      = 1'b1;
                    addr_d    = pix_cnt_q;
                    data_d    = rx_data[0];
                    pix_cnt_d = pix_cnt_q + 1'b1;
                    bit_d     = 3'd1;
                    state_d   = WRITE;
`ifdef SNN_LOADER_TIMEOUT_EN
                    gap_d     = '0;
`endif
                end
`ifdef SNN_LOADER_TIMEOUT_EN
                else if (pix_cnt_q != '0) begin
                    if (gap_q == GAP_LAST) begin
                        // Upstream went quiet mid-frame: drop the partial image.
                        gap_d       = '0;
                        pix_cnt_d   = '0;
                        busy_d      = 1'b0;
                        frame_err_d = 1'b1;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
`endif
            end

            WRITE: begin
                we_d      = 1'b1;
                addr_d    = pix_cnt_q;
                data_d    = byte_q[bit_q];
                pix_cnt_d = pix_cnt_q + 1'b1;
                bit_d     = bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    state_d = (pix_cnt_q == LAST_PIX) ? START : WAIT_BYTE;
                end
            end

            START: begin
                strt_d    = 1'b1;
                pix_cnt_d = '0;
                state_d   = BUSY;
            end

            BUSY: begin
                // A done coincident with our own strt belongs to an older run.
                if (done && !strt_q) begin
                    busy_d  = 1'b0;
                    state_d = WAIT_BYTE;
                end
            end

            default: state_d = WAIT_BYTE;
        endcase
    end

    // State and output registers; async reset discards any partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WAIT_BYTE;
            pix_cnt_q <= '0;
            byte_q    <= '0;
            bit_q     <= '0;
            clr_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= 1'b0;
            strt_q    <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SNN_LOADER_TIMEOUT_EN
            gap_q       <= '0;
            frame_err_q <= 1'b0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop
            // samples the pre-edge values regardless of statement order.
            state_q   <= state_d;
            pix_cnt_q <= pix_cnt_d;
            byte_q    <= byte_d;
            bit_q     <= bit_d;
            clr_q     <= clr_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strt_q    <= strt_d;
            busy_q    <= busy_d;
`ifdef SNN_LOADER_TIMEOUT_EN
            gap_q       <= gap_d;
            frame_err_q <= frame_err_d;
`endif
        end
    end

    assign clr_rx_rdy = clr_q;
    assign ram_we     = we_q;
    assign ram_addr   = addr_q;
    assign ram_data   = data_q;
    assign strt       = strt_q;
    assign busy       = busy_q;

`ifdef SNN_LOADER_TIMEOUT_EN
    assign frame_err = frame_err_q;
`else
    // Without the timeout a partial frame waits forever; the limit is unused.
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT_CYCLES;
    assign frame_err      = 1'b0;
`endif

endmodule
